hex_display_scheduler: RTL and testbench
========================================

Name: hex_display_scheduler

Overview:
Sequencer and shared-update controller for the 3-digit multiplexed 7-segment display. It holds shadow and active digit registers written through a valid/ready port. Committed updates transfer to the display atomically at frame boundaries. It time-multiplexes digits with an anti-ghosting blanking gap and a 16-level brightness duty cycle, driving the board's digit-select and segment lines directly.

Parameters:
DIGITS, 3, number of multiplexed digits (1..4)
SLOT_CYCLES, 2048, Clk cycles per brightness slot; each digit period has 16 slots
BLANK_CYCLES, 64, Clk cycles all digits are off before each digit's on-window (BLANK_CYCLES >= 1)

Ports:
Clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = scan display; 0 = blank and hold scanner in IDLE
brightness  in  4  on-duty; the digit is lit for (brightness+1) of 16 slots
wr_valid  in  1  shadow write request
wr_ready  out  1  shadow write accepted when wr_valid and wr_ready are both high
wr_digit  in  2  target digit index
wr_data  in  4  hex nibble for the target digit
wr_dp  in  1  decimal point for the target digit (1 = lit)
commit  in  1  one-cycle pulse requesting a shadow-to-active transfer
SEG_SEL  out  DIGITS  one-hot digit enable, active-high
HEX_OUT  out  8  {dp_n, seg[6:0]}, active-low, hexdriver encoding
frame_start  out  1  one-cycle pulse when digit 0 enters BLANK

Behaviour:
- Reset (asynchronous, while reset_n=0): SEG_SEL=0, HEX_OUT=8'hFF, wr_ready=1, frame_start=0. All shadow/active nibbles and dp bits = 0. pending=0. FSM=IDLE. Counters = 0.
- Digit period = BLANK_CYCLES + 16*SLOT_CYCLES cycles. Frame = DIGITS digit periods.
- FSM states:
  - IDLE: if enable=1, go to BLANK with digit index 0.
  - BLANK: hold for BLANK_CYCLES cycles, then go to ON.
  - ON: hold for (brightness+1)*SLOT_CYCLES cycles. If brightness=15, go to NEXT; otherwise go to OFF.
  - OFF: hold for the remainder of the 16*SLOT_CYCLES window, then go to NEXT.
  - NEXT: a 0-cycle decision taken on the same edge as the ON/OFF exit. The index increments and wraps from DIGITS-1 to 0. The FSM enters BLANK.
- brightness is sampled once on BLANK->ON and held for that digit period. A change takes effect on the next digit.
- Outputs are registered, one cycle after state:
  - ON: SEG_SEL = 1<<idx, HEX_OUT = {~dp[idx], hexdriver(active[idx])}.
  - IDLE, BLANK, OFF: SEG_SEL=0, HEX_OUT=8'hFF.
- frame_start is asserted for exactly one cycle, coincident with the registered entry into BLANK for idx 0. This includes the first entry from IDLE.
- Write port:
  - A handshake writes wr_data and wr_dp into shadow[wr_digit].
  - wr_digit >= DIGITS: the handshake completes and the data is discarded.
  - wr_ready = ~pending.
- Commit:
  - commit=1 sets pending. commit while already pending has no further effect.
  - A write and commit in the same cycle: the write lands first and is included in the commit.
- Transfer:
  - When pending=1 and the FSM enters BLANK for idx 0, active <= shadow for all digits and pending clears on that edge.
  - In IDLE, or when enable=0, the transfer occurs on the next cycle.
- Active registers never change mid-frame (no tearing).
- enable falling: on the next edge the FSM goes to IDLE, counters clear, and outputs blank on the following edge. On re-enable, scanning restarts at digit 0.
- Reset asserted mid-operation: all state and outputs return immediately to reset values. No partial commit survives.

Test Plan:
- SLOT_CYCLES=4, BLANK_CYCLES=2, brightness=15, enable=1, all active=0.
  - Required: SEG_SEL cycles 001,010,100. Each digit is off 2 cycles then lit 64 cycles.
  - Required: frame_start pulses every 198 cycles.
  - Required: HEX_OUT=8'hC0 while lit.
- brightness=3, same parameters.
  - Required: each digit is lit 16 cycles and dark 50 cycles.
- Write the shadow mid-frame, without commit.
  - Write: digit 0 <- 4'hA with dp=1, digit 1 <- 4'h5, digit 2 <- 4'hF.
  - Required: the display is unchanged.
- Pulse commit after those writes.
  - Required: wr_ready=0 until the next frame_start.
  - Required: in the next frame, digits show HEX_OUT = 8'h08, 8'h92, 8'h8E.
- wr_valid held during pending.
  - Required: no handshake until pending clears.
- Write wr_digit=3.
  - Required: the handshake completes and no digit changes.
- Drop enable for 10 cycles mid-ON.
  - Required: SEG_SEL=0 and HEX_OUT=8'hFF within 2 cycles.
  - Required: on re-enable, scanning restarts at digit 0 with frame_start.
- Pulse reset_n low asynchronously between clock edges.
  - Required: outputs reach reset values without waiting for Clk.

Source files
------------

// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler: multiplexed 7-segment scanner with shadow/active digit registers, frame-atomic commit, blanking gap and 16-level brightness
// Ports:
//   Clk, reset_n            clock and asynchronous active-low reset
//   enable                  1 = scan, 0 = blank and idle
//   brightness[3:0]         digit lit for brightness+1 of 16 slots
//   wr_valid/wr_ready       shadow write handshake (wr_digit, wr_data, wr_dp)
//   commit                  request shadow-to-active transfer at next frame start
//   SEG_SEL[DIGITS-1:0]     one-hot digit enable, active-high
//   HEX_OUT[7:0]            {dp_n, seg[6:0]} active-low
//   frame_start             one-cycle pulse as digit 0 enters its blanking gap
module hex_display_scheduler #(
    parameter int DIGITS       = 3,
    parameter int SLOT_CYCLES  = 2048,
    parameter int BLANK_CYCLES = 64
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [3:0]        brightness,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [1:0]        wr_digit,
    input  logic [3:0]        wr_data,
    input  logic              wr_dp,
    input  logic              commit,
    output logic [DIGITS-1:0] SEG_SEL,
    output logic [7:0]        HEX_OUT,
    output logic              frame_start
);
    localparam int WIN = 16 * SLOT_CYCLES;
    localparam int CW  = $clog2(WIN + BLANK_CYCLES + 1);
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, BLANK, ON, OFF} state_t;

    state_t        st, st_n;
    logic [CW-1:0] cnt, cnt_n, on_last;
    logic [IW-1:0] idx, idx_n, idx_inc;
    logic [3:0]    bri;
    logic          pending, xfer, blank_done, win_done;
    logic [3:0]    shadow [DIGITS];
    logic          shadow_dp [DIGITS];
    logic [3:0]    act [DIGITS];
    logic          act_dp [DIGITS];

    function automatic logic [6:0] hexdriver(input logic [3:0] v);
        case (v)
            4'h0: hexdriver = 7'h40;
            4'h1: hexdriver = 7'h79;
            4'h2: hexdriver = 7'h24;
            4'h3: hexdriver = 7'h30;
            4'h4: hexdriver = 7'h19;
            4'h5: hexdriver = 7'h12;
            4'h6: hexdriver = 7'h02;
            4'h7: hexdriver = 7'h78;
            4'h8: hexdriver = 7'h00;
            4'h9: hexdriver = 7'h10;
            4'hA: hexdriver = 7'h08;
            4'hB: hexdriver = 7'h03;
            4'hC: hexdriver = 7'h46;
            4'hD: hexdriver = 7'h21;
            4'hE: hexdriver = 7'h06;
            default: hexdriver = 7'h0E;
        endcase
    endfunction

    // one counter spans the whole ON+OFF window; ON ends at on_last, the window at WIN-1
    assign on_last    = CW'((32'(bri) + 1) * SLOT_CYCLES - 1);
    assign win_done   = cnt == CW'(WIN - 1);
    assign blank_done = cnt == CW'(BLANK_CYCLES - 1);
    assign idx_inc    = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    assign wr_ready   = ~pending;

    always_comb begin
        st_n  = st;
        cnt_n = cnt + 1'b1;
        idx_n = idx;
        case (st)
            IDLE:    st_n = enable ? BLANK : IDLE;
            BLANK:   st_n = blank_done ? ON : BLANK;
            ON:      st_n = win_done ? BLANK : (cnt == on_last) ? OFF : ON;
            default: st_n = win_done ? BLANK : OFF;
        endcase
        if (st == IDLE || (st == BLANK && blank_done)) cnt_n = '0;
        if ((st == ON || st == OFF) && win_done) begin
            cnt_n = '0;
            idx_n = idx_inc;
        end
        if (!enable || st == IDLE) idx_n = '0;
        if (!enable) begin
            st_n  = IDLE;
            cnt_n = '0;
        end
    end

    // transfer only on the edge that starts a frame, or immediately when not scanning
    assign xfer = pending && (st == IDLE || !enable || (st_n == BLANK && idx_n == '0 && st != BLANK));

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            st          <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            bri         <= '0;
            pending     <= 1'b0;
            SEG_SEL     <= '0;
            HEX_OUT     <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            st          <= st_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            bri         <= (st == BLANK && blank_done) ? brightness : bri;
            pending     <= xfer ? 1'b0 : pending | commit;
            SEG_SEL     <= (st == ON) ? DIGITS'(1) << idx : '0;
            HEX_OUT     <= (st == ON) ? {~act_dp[idx], hexdriver(act[idx])} : 8'hFF;
            frame_start <= st == BLANK && cnt == '0 && idx == '0;
        end
    end

    // writes need ~pending and transfers need pending, so they never collide
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                shadow[i]    <= '0;
                shadow_dp[i] <= 1'b0;
                act[i]       <= '0;
                act_dp[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (wr_valid && wr_ready && wr_digit == 2'(i)) begin
                    shadow[i]    <= wr_data;
                    shadow_dp[i] <= wr_dp;
                end
                if (xfer) begin
                    act[i]    <= shadow[i];
                    act_dp[i] <= shadow_dp[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb_hex_display_scheduler: scoreboard bench checking lit windows, frame timing, commit and reset behaviour
module tb_hex_display_scheduler;
    logic       Clk = 1'b0;
    logic       reset_n, enable, wr_valid, wr_ready, wr_dp, commit, frame_start;
    logic [3:0] brightness, wr_data;
    logic [1:0] wr_digit;
    logic [2:0] SEG_SEL;
    logic [7:0] HEX_OUT;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] hex;
        int         lit;
        int         gap;
    } win_t;

    win_t q[$];
    win_t e;
    int   errors = 0, checks = 0;
    int   cyc = 0, fs_last = -1, fs_period = 0;
    int   lit = 0, dark = 0, gap = 0, n = 0;
    logic [2:0] prev_sel = '0, cur_sel = '0;
    logic [7:0] cur_hex = '0;
    logic       tear = 1'b0;

    hex_display_scheduler #(.DIGITS(3), .SLOT_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .Clk(Clk), .reset_n(reset_n), .enable(enable), .brightness(brightness),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_digit(wr_digit), .wr_data(wr_data),
        .wr_dp(wr_dp), .commit(commit), .SEG_SEL(SEG_SEL), .HEX_OUT(HEX_OUT),
        .frame_start(frame_start)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push3(input logic [7:0] h0, input logic [7:0] h1, input logic [7:0] h2,
                         input int l, input int g0, input int g);
        win_t w;
        w.lit = l;
        w.sel = 3'b001; w.hex = h0; w.gap = g0; q.push_back(w);
        w.sel = 3'b010; w.hex = h1; w.gap = g;  q.push_back(w);
        w.sel = 3'b100; w.hex = h2; w.gap = g;  q.push_back(w);
    endtask

    // returns one cycle after frame_start, before digit 0 lights
    task automatic next_frame();
        int k;
        k = 0;
        do begin
            @(negedge Clk);
            k++;
        end while (frame_start !== 1'b1 && k < 500);
        check("frame_seen", 32'(frame_start), 32'd1);
        @(negedge Clk);
    endtask

    task automatic do_write(input logic [1:0] d, input logic [3:0] v, input logic p);
        wr_digit = d; wr_data = v; wr_dp = p; wr_valid = 1'b1;
        for (int k = 0; k < 50 && !wr_ready; k++) @(negedge Clk);
        check("wr_accept", 32'(wr_ready), 32'd1);
        @(negedge Clk);
        wr_valid = 1'b0;
    endtask

    // window monitor: each lit window is compared against the next scoreboard entry
    always @(negedge Clk) begin
        if (!reset_n) begin
            prev_sel = '0; dark = 0; lit = 0; tear = 1'b0; fs_last = -1;
        end else begin
            cyc++;
            if (frame_start) begin
                if (fs_last >= 0) fs_period = cyc - fs_last;
                fs_last = cyc;
            end
            if (SEG_SEL != '0) begin
                if (prev_sel == '0) begin
                    cur_sel = SEG_SEL; cur_hex = HEX_OUT; lit = 1; gap = dark; tear = 1'b0;
                end else begin
                    lit++;
                    if (SEG_SEL !== cur_sel || HEX_OUT !== cur_hex) tear = 1'b1;
                end
            end else begin
                if (prev_sel != '0) begin
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("win_sel", 32'(cur_sel), 32'(e.sel));
                        check("win_hex", 32'(cur_hex), 32'(e.hex));
                        check("win_lit", 32'(lit), 32'(e.lit));
                        check("win_stable", 32'(tear), 32'd0);
                        if (e.gap >= 0) check("win_gap", 32'(gap), 32'(e.gap));
                    end
                    dark = 1;
                end else dark++;
            end
            prev_sel = SEG_SEL;
        end
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; brightness = 4'd15; wr_valid = 1'b0;
        wr_digit = '0; wr_data = '0; wr_dp = 1'b0; commit = 1'b0;
        #23;
        check("rst_sel", 32'(SEG_SEL), 32'd0);
        check("rst_hex", 32'(HEX_OUT), 32'hFF);
        check("rst_ready", 32'(wr_ready), 32'd1);
        check("rst_fs", 32'(frame_start), 32'd0);
        @(negedge Clk) reset_n = 1'b1;
        @(negedge Clk);
        check("idle_sel", 32'(SEG_SEL), 32'd0);
        enable = 1'b1;
        // full brightness
        next_frame();
        push3(8'hC0, 8'hC0, 8'hC0, 64, -1, 2);
        next_frame();
        check("q_drained_b15a", 32'(q.size()), 32'd0);
        check("frame_period_b15", 32'(fs_period), 32'd198);
        push3(8'hC0, 8'hC0, 8'hC0, 64, 2, 2);
        next_frame();
        check("q_drained_b15b", 32'(q.size()), 32'd0);
        // brightness 3: the current frame is mixed, so check the following one
        brightness = 4'd3;
        next_frame();
        push3(8'hC0, 8'hC0, 8'hC0, 16, 50, 50);
        next_frame();
        check("q_drained_b3", 32'(q.size()), 32'd0);
        check("frame_period_b3", 32'(fs_period), 32'd198);
        // shadow writes without commit leave the display alone
        push3(8'hC0, 8'hC0, 8'hC0, 16, 50, 50);
        repeat (20) @(negedge Clk);
        do_write(2'd0, 4'hA, 1'b1);
        do_write(2'd1, 4'h5, 1'b0);
        do_write(2'd2, 4'hF, 1'b0);
        next_frame();
        check("q_drained_nocommit", 32'(q.size()), 32'd0);
        // commit, then hold a write to digit 3 while pending
        repeat (20) @(negedge Clk);
        commit = 1'b1;
        @(negedge Clk) commit = 1'b0;
        check("pending_ready", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1; wr_digit = 2'd3; wr_data = 4'h7; wr_dp = 1'b1;
        for (int k = 0; k < 600 && !wr_ready; k++) @(negedge Clk);
        check("pending_clear", 32'(wr_ready), 32'd1);
        check("ready_before_fs", 32'(frame_start), 32'd0);
        @(negedge Clk);
        check("fs_after_xfer", 32'(frame_start), 32'd1);
        wr_valid = 1'b0;
        @(negedge Clk);
        push3(8'h08, 8'h92, 8'h8E, 16, 50, 50);
        next_frame();
        check("q_drained_commit", 32'(q.size()), 32'd0);
        // recommit: current frame must not tear, next shows digit-3 write had no effect
        push3(8'h08, 8'h92, 8'h8E, 16, 50, 50);
        repeat (5) @(negedge Clk);
        commit = 1'b1;
        @(negedge Clk) commit = 1'b0;
        next_frame();
        check("q_drained_notear", 32'(q.size()), 32'd0);
        push3(8'h08, 8'h92, 8'h8E, 16, 50, 50);
        next_frame();
        check("q_drained_d3", 32'(q.size()), 32'd0);
        // drop enable mid-ON; commit while idle transfers on the next cycle
        repeat (5) @(negedge Clk);
        check("lit_before_disable", 32'(SEG_SEL), 32'd1);
        enable = 1'b0;
        repeat (2) @(negedge Clk);
        check("disable_sel", 32'(SEG_SEL), 32'd0);
        check("disable_hex", 32'(HEX_OUT), 32'hFF);
        do_write(2'd0, 4'h0, 1'b0);
        commit = 1'b1;
        @(negedge Clk) commit = 1'b0;
        check("idle_pending", 32'(wr_ready), 32'd0);
        @(negedge Clk);
        check("idle_xfer", 32'(wr_ready), 32'd1);
        repeat (3) @(negedge Clk);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (frame_start !== 1'b1 && n < 20);
        check("restart_latency", 32'(n), 32'd2);
        @(negedge Clk);
        push3(8'hC0, 8'h92, 8'h8E, 16, -1, 50);
        next_frame();
        check("q_drained_restart", 32'(q.size()), 32'd0);
        // asynchronous reset between edges discards a pending commit
        repeat (5) @(negedge Clk);
        commit = 1'b1;
        @(negedge Clk) commit = 1'b0;
        repeat (3) @(negedge Clk);
        check("pre_reset_pending", 32'(wr_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("async_sel", 32'(SEG_SEL), 32'd0);
        check("async_hex", 32'(HEX_OUT), 32'hFF);
        check("async_fs", 32'(frame_start), 32'd0);
        check("async_ready", 32'(wr_ready), 32'd1);
        @(negedge Clk) reset_n = 1'b1;
        next_frame();
        push3(8'hC0, 8'hC0, 8'hC0, 16, -1, 50);
        next_frame();
        check("q_drained_post_reset", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
